// File: rtl/logic_cfg_writer_if.sv
// Word handshake between a configuration source and the chain writer.
interface logic_cfg_writer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [8:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/logic_cfg_writer.sv
// Streams 9-bit cell words onto a serial configuration chain, capturing the
// previous chain contents as readback, then strobes the cell latches.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_WAIT  | ready for the next cell word
// S_SHIFT | shifting one word out on sdo, readback in on sdi
// S_LOAD  | one-cycle transfer of the chain into the cell latches
module logic_cfg_writer #(
    parameter int NCELLS = 8,
    parameter int WORD_W = 9
) (
    input  logic                 qck,
    input  logic                 qrn,
    input  logic                 start,
    logic_cfg_writer_if.slave    cfg,
    output logic                 sen,
    output logic                 sdo,
    input  logic                 sdi,
    output logic                 cload,
    output logic                 rd_valid,
    output logic [WORD_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [5:0] LAST_CELL = 6'(NCELLS - 1);
    localparam logic [3:0] LAST_BIT  = 4'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        cell_cnt;
    logic [3:0]        bit_cnt;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nxt;
    logic              hs;
    logic              last_bit;

    assign hs       = cfg.cfg_valid & cfg.cfg_ready;
    assign last_bit = (bit_cnt == LAST_BIT);
    // Readback enters at the top so the far-end bit lands in bit0 after a word.
    assign sreg_nxt = {sdi, sreg[WORD_W-1:1]};

    always_ff @(posedge qck or negedge qrn) begin
        if (!qrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        sen           = 1'b0;
        cload         = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                cfg.cfg_ready = 1'b1;
                if (hs) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                sen = 1'b1;
                if (last_bit) state_nxt = (cell_cnt == LAST_CELL) ? S_LOAD : S_WAIT;
            end
            S_LOAD: begin
                cload     = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gating keeps the chain input quiet whenever it is not shifting.
    assign sdo = sen & sreg[0];

    always_ff @(posedge qck or negedge qrn) begin
        if (!qrn) begin
            cell_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) cell_cnt <= '0;
                end
                S_WAIT: begin
                    if (hs) begin
                        sreg    <= cfg.cfg_data;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg    <= sreg_nxt;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (last_bit) begin
                        rd_valid <= 1'b1;
                        rd_data  <= sreg_nxt;
                        if (cell_cnt != LAST_CELL) cell_cnt <= cell_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_cfg_writer.sv
// Directed bench: a one-cell writer for the basic shift pattern and a two-cell
// writer driving a behavioural chain with loopback and preloaded contents.
module tb_logic_cfg_writer;

    logic qck = 1'b0;
    logic qrn;
    logic start1, start2, sdi1, sdi2;
    logic sen1, sdo1, cload1, rd_valid1, busy1, done1;
    logic sen2, sdo2, cload2, rd_valid2, busy2, done2;
    logic [8:0] rd_data1, rd_data2;

    logic_cfg_writer_if b1 ();
    logic_cfg_writer_if b2 ();

    logic_cfg_writer #(.NCELLS(1), .WORD_W(9)) dut1 (
        .qck(qck), .qrn(qrn), .start(start1), .cfg(b1),
        .sen(sen1), .sdo(sdo1), .sdi(sdi1), .cload(cload1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1), .done(done1)
    );

    logic_cfg_writer #(.NCELLS(2), .WORD_W(9)) dut2 (
        .qck(qck), .qrn(qrn), .start(start2), .cfg(b2),
        .sen(sen2), .sdo(sdo2), .sdi(sdi2), .cload(cload2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2), .done(done2)
    );

    always #5 qck = ~qck;

    int n_chk = 0;
    int n_err = 0;
    int overlap_cnt = 0;
    int sdo_err_cnt = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int cload_cnt2 = 0;

    // Two-cell chain model: index 0 sits next to sdo, index 17 feeds sdi.
    logic [17:0] chain = '0;
    logic [17:0] pre_val;
    logic        preload;
    logic [8:0]  rd_got [2];

    always @(posedge qck) begin
        if (preload) chain <= pre_val;
        else if (sen2) chain <= {chain[16:0], sdo2};
    end
    assign sdi2 = chain[17];

    always @(negedge qck) begin
        if ((sen1 && cload1) || (sen2 && cload2)) overlap_cnt <= overlap_cnt + 1;
        if ((!sen1 && sdo1) || (!sen2 && sdo2)) sdo_err_cnt <= sdo_err_cnt + 1;
        if (done1)  done_cnt1  <= done_cnt1 + 1;
        if (done2)  done_cnt2  <= done_cnt2 + 1;
        if (cload2) cload_cnt2 <= cload_cnt2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs1();
        return {b1.cfg_ready, sen1, sdo1, cload1, rd_valid1, rd_data1, busy1, done1};
    endfunction

    function automatic logic [15:0] outs2();
        return {b2.cfg_ready, sen2, sdo2, cload2, rd_valid2, rd_data2, busy2, done2};
    endfunction

    // One pass on the two-cell writer; len is the cycle (WAIT = 1) where done shows.
    task automatic run_pass(input logic [8:0] w0, input logic [8:0] w1, input int stall,
                            input bit restart, input string tag, output int len);
        logic [8:0] words [2];
        int  widx = 0;
        int  run = 0;
        int  prev_run = 0;
        int  nrd = 0;
        bit  hs;
        bit  fin = 1'b0;
        words[0] = w0;
        words[1] = w1;
        len = 0;
        start2 = 1'b1;
        @(posedge qck); #1;
        start2 = 1'b0;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            b2.cfg_valid = (cyc > stall);
            b2.cfg_data  = words[widx];
            start2       = restart && (sen2 || cload2);
            if (cyc <= stall) chk({tag, "_stall"}, {sen2, sdo2, b2.cfg_ready}, 3'b001);
            if (rd_valid2) begin
                chk({tag, "_rd_lat"}, prev_run, 9);
                if (nrd < 2) rd_got[nrd] = rd_data2;
                nrd++;
            end
            run      = sen2 ? run + 1 : 0;
            prev_run = run;
            if (done2) begin
                fin = 1'b1;
                len = cyc;
            end
            hs = b2.cfg_valid && b2.cfg_ready;
            @(posedge qck); #1;
            if (hs && widx == 0) widx = 1;
        end
        b2.cfg_valid = 1'b0;
        start2       = 1'b0;
        chk({tag, "_fin"}, fin, 1);
        chk({tag, "_nrd"}, nrd, 2);
    endtask

    logic [8:0] exp_sdo_a;
    logic [8:0] far_pre, near_pre, near_got, far_got;
    int len;
    int d0;

    initial begin
        qrn = 1'b0;
        start1 = 1'b0; start2 = 1'b0; sdi1 = 1'b0; preload = 1'b0;
        b1.cfg_valid = 1'b0; b1.cfg_data = '0;
        b2.cfg_valid = 1'b0; b2.cfg_data = '0;
        exp_sdo_a = 9'b1_0101_0101;
        far_pre   = 9'h0A5;
        near_pre  = 9'h13C;
        for (int k = 0; k < 9; k++) begin
            pre_val[17-k] = far_pre[k];
            pre_val[8-k]  = near_pre[k];
        end

        #3;
        chk("rst_out1", outs1(), 16'h0);
        chk("rst_out2", outs2(), 16'h0);
        #19 qrn = 1'b1;
        @(posedge qck); #1;
        chk("idle_busy", {busy1, busy2}, 2'b00);

        // One-cell pass, 9'h155 with sdi tied low.
        b1.cfg_valid = 1'b1; b1.cfg_data = 9'h155; start1 = 1'b1;
        @(posedge qck); #1;
        start1 = 1'b0;
        chk("a_wait", {busy1, b1.cfg_ready, sen1}, 3'b110);
        @(posedge qck); #1;
        b1.cfg_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk("a_sen", sen1, 1);
            chk("a_sdo", sdo1, exp_sdo_a[k]);
            @(posedge qck); #1;
        end
        chk("a_load", {cload1, done1, sen1, rd_valid1}, 4'b1101);
        chk("a_rd", rd_data1, 9'h000);
        @(posedge qck); #1;
        chk("a_idle", {busy1, cload1, done1}, 3'b000);
        chk("a_done_cnt", done_cnt1, 1);

        // Two-cell pass with loopback; previous chain contents come back.
        preload = 1'b1;
        @(posedge qck); #1;
        preload = 1'b0;
        d0 = done_cnt2;
        run_pass(9'h1FF, 9'h001, 0, 1'b0, "b", len);
        chk("b_len", len, 21);
        chk("b_rd0", rd_got[0], 9'h0A5);
        chk("b_rd1", rd_got[1], 9'h13C);
        for (int k = 0; k < 9; k++) begin
            near_got[k] = chain[8-k];
            far_got[k]  = chain[17-k];
        end
        chk("b_near", near_got, 9'h001);
        chk("b_far", far_got, 9'h1FF);
        chk("b_done_cnt", done_cnt2 - d0, 1);

        // Valid withheld 5 cycles in the first WAIT.
        d0 = done_cnt2;
        run_pass(9'h0F0, 9'h10F, 5, 1'b0, "c", len);
        chk("c_len", len, 26);
        chk("c_rd0", rd_got[0], 9'h1FF);
        chk("c_rd1", rd_got[1], 9'h001);
        chk("c_done_cnt", done_cnt2 - d0, 1);

        // Start held during SHIFT and LOAD must not launch another pass.
        d0 = done_cnt2;
        run_pass(9'h033, 9'h1C4, 0, 1'b1, "d", len);
        chk("d_len", len, 21);
        chk("d_rd0", rd_got[0], 9'h0F0);
        chk("d_rd1", rd_got[1], 9'h10F);
        repeat (3) @(posedge qck);
        #1;
        chk("d_idle", busy2, 0);
        chk("d_done_cnt", done_cnt2 - d0, 1);

        // Reset during the 4th SHIFT cycle.
        d0 = cload_cnt2;
        b2.cfg_valid = 1'b1; b2.cfg_data = 9'h1AB; start2 = 1'b1;
        @(posedge qck); #1;
        start2 = 1'b0;
        repeat (4) @(posedge qck);
        #1;
        chk("e_shift4", {sen2, busy2}, 2'b11);
        #2 qrn = 1'b0;
        #1;
        chk("e_rst_out2", outs2(), 16'h0);
        @(posedge qck); #1;
        chk("e_rst_hold", outs2(), 16'h0);
        #2 qrn = 1'b1;
        repeat (4) @(posedge qck);
        #1;
        chk("e_no_restart", busy2, 0);
        chk("e_no_cload", cload_cnt2 - d0, 0);
        b2.cfg_valid = 1'b0;

        @(posedge qck); #1;
        chk("sen_cload_overlap", overlap_cnt, 0);
        chk("sdo_without_sen", sdo_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/logic_cfg_writer.md
LOGIC_CFG_WRITER -- requirements
Module: logic_cfg_writer

Interface
REQ-001 SHALL have parameter NCELLS, default 8: number of logic cells on the configuration chain (legal range 1..64).
REQ-002 SHALL have parameter WORD_W, default 9: configuration bits per cell, fixed 9.
REQ-003 SHALL have port QCK, input, 1 bit: single clock; all sequential logic on its rising edge.
REQ-004 SHALL have port QRN, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port START, input, 1 bit: begin a chain-programming pass; sampled only in IDLE.
REQ-006 SHALL have port CFG_VALID, input, 1 bit: CFG_DATA holds a valid cell word.
REQ-007 SHALL have port CFG_READY, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port CFG_DATA, input, 9 bits: bit order {Z_QCKS,BBS2,BBS1,BAS2,BAS1,TBS2,TBS1,TAS2,TAS1}, bit0 = TAS1.
REQ-009 SHALL have port SEN, output, 1 bit: chain shift enable.
REQ-010 SHALL have port SDO, output, 1 bit: serial data into the chain.
REQ-011 SHALL have port SDI, input, 1 bit: serial data out of the chain's far end (readback).
REQ-012 SHALL have port CLOAD, output, 1 bit: one-cycle pulse transferring the chain into cell configuration latches.
REQ-013 SHALL have port RD_VALID, output, 1 bit: one-cycle pulse qualifying RD_DATA.
REQ-014 SHALL have port RD_DATA, output, 9 bits: previous chain contents, one cell word, same bit order as CFG_DATA.
REQ-015 SHALL have port BUSY, output, 1 bit: state is not IDLE.
REQ-016 SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of a pass.

Function
REQ-017 SHALL implement states IDLE, WAIT, SHIFT, LOAD.
REQ-018 IDLE: START=1 -> WAIT; cell counter cleared to 0; START=0 -> stay.
REQ-019 WAIT: CFG_READY=1; a handshake (CFG_VALID & CFG_READY) captures CFG_DATA into a 9-bit shift register and moves to SHIFT; the bit counter is cleared to 0.
REQ-020 SHIFT: SEN=1 for exactly 9 consecutive cycles; SDO = shift register bit0; the register shifts right each cycle with SDI entering bit8; CFG_READY=0.
REQ-021 After the 9th SHIFT cycle, the shift register holds the outgoing chain word. RD_DATA SHALL take that value and RD_VALID SHALL pulse in the following cycle.
REQ-022 After SHIFT, if the cell counter equals NCELLS-1 -> LOAD; otherwise the cell counter increments and the state returns to WAIT.
REQ-023 LOAD: CLOAD=1 and DONE=1 for exactly one cycle, then IDLE.
REQ-024 Words SHALL be written in acceptance order. The first word accepted programs the cell farthest from SDO, so it is shifted furthest.
REQ-025 Minimum pass length SHALL be NCELLS*10+1 cycles after START when CFG_VALID is held high: WAIT 1 + SHIFT 9 per cell, plus LOAD 1.
REQ-026 CFG_VALID low in WAIT SHALL stall indefinitely with SEN=0 and SDO held at 0.
REQ-027 START asserted while BUSY=1 SHALL be ignored.
REQ-028 SEN=0 implies SDO=0; SEN and CLOAD SHALL never be high in the same cycle.
REQ-029 Cell counter width SHALL be 6 bits. It SHALL never exceed NCELLS-1 and SHALL not wrap within a pass.

Reset
REQ-030 QRN=0 SHALL immediately force state IDLE, all counters 0, the shift register 0, and outputs CFG_READY=0, SEN=0, SDO=0, CLOAD=0, RD_VALID=0, RD_DATA=0, BUSY=0, DONE=0.
REQ-031 Reset mid-pass SHALL abort without a CLOAD pulse. After QRN is released, a new START is required.
REQ-032 Release of QRN SHALL take effect at the first QCK rising edge after deassertion.

Verification
REQ-033 Scenario: NCELLS=1, START, CFG_DATA=9'h155, SDI=0 -> SDO sequence 1,0,1,0,1,0,1,0,1 over 9 cycles; CLOAD one cycle later; total 11 cycles.
REQ-034 Scenario: NCELLS=2, words 9'h1FF then 9'h001, SDI loopback delayed 18 cycles -> chain model holds {9'h001 near SDO, 9'h1FF far}; DONE pulses once.
REQ-035 Scenario: readback with SDI driven as 9'h0A5 serial, LSB first -> RD_DATA=9'h0A5 and RD_VALID pulses 1 cycle after the 9th SEN cycle.
REQ-036 Scenario: CFG_VALID withheld 5 cycles in WAIT -> SEN=0 throughout; pass length extended by exactly 5.
REQ-037 Scenario: QRN pulled low at the 4th SHIFT cycle -> all outputs 0 asynchronously; no CLOAD; BUSY=0.
REQ-038 Scenario: START re-asserted during SHIFT -> ignored; exactly one DONE per pass.
